// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. Arbitrates, in fixed
// priority, halt requests, multi-cycle data-memory waits, taken-branch flushes
// and load-use hazards, and drives the PC enable plus the enable/flush/bubble
// controls of the four pipeline registers. A saturating counter records stall
// cycles, and a sticky error halts the pipeline if memory never answers.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   id_rs1, id_rs2               source registers of the instruction in ID
//   id_uses_rs1, id_uses_rs2     ID instruction actually reads rs1 / rs2
//   ex_rd, ex_is_load            destination and load flag of the EX instruction
//   branch_taken                 branch resolved taken in EX
//   mem_req, mem_ready           MEM-stage access pending / completing this cycle
//   halt                         halt request
//   pc_en, pr1_en..pr4_en        PC and IF/ID, ID/EX, EX/MEM, MEM/WB load enables
//   pr1_flush                    IF/ID loads a NOP (qualified by pr1_en)
//   pr2_bubble                   ID/EX loads a NOP (qualified by pr2_en)
//   pr4_bubble                   MEM/WB loads a bubble, RF write off (qualified by pr4_en)
//   state                        0 RUN, 1 MEM_WAIT, 2 HALTED
//   stall_cnt                    saturating count of stalled cycles outside HALTED
//   mem_timeout_err              sticky memory-timeout flag
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 3,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  halt,
    output logic                  pc_en,
    output logic                  pr1_en,
    output logic                  pr2_en,
    output logic                  pr3_en,
    output logic                  pr4_en,
    output logic                  pr1_flush,
    output logic                  pr2_bubble,
    output logic                  pr4_bubble,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  mem_timeout_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    stall_q;
    logic                err_q, err_d;

    logic lu_hazard;
    logic pc_en_c, pr1_en_c, pr2_en_c, pr3_en_c, pr4_en_c;
    logic pr1_flush_c, pr2_bubble_c, pr4_bubble_c;
    logic advance, freeze;

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lu_hazard = ex_is_load && (ex_rd != '0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Next-state logic picks one of three output flavours: all-off (halt or
    // HALTED), freeze (memory outstanding: only MEM/WB moves, as a bubble) or
    // advance (normal flow, with branch flush beating the load-use stall).
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        advance = 1'b0;
        freeze  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (mem_req && !mem_ready) begin
                    freeze  = 1'b1;
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (mem_ready) begin
                    advance = 1'b1;
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_HALTED;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Output decode from the chosen flavour; a branch held through a memory
    // wait only takes effect here, on the advancing cycle.
    always_comb begin
        pc_en_c      = 1'b0;
        pr1_en_c     = 1'b0;
        pr2_en_c     = 1'b0;
        pr3_en_c     = 1'b0;
        pr4_en_c     = 1'b0;
        pr1_flush_c  = 1'b0;
        pr2_bubble_c = 1'b0;
        pr4_bubble_c = 1'b0;

        if (freeze) begin
            pr4_en_c     = 1'b1;
            pr4_bubble_c = 1'b1;
        end else if (advance) begin
            pr2_en_c = 1'b1;
            pr3_en_c = 1'b1;
            pr4_en_c = 1'b1;
            if (branch_taken) begin
                pc_en_c      = 1'b1;
                pr1_en_c     = 1'b1;
                pr1_flush_c  = 1'b1;
                pr2_bubble_c = 1'b1;
            end else if (lu_hazard) begin
                pr2_bubble_c = 1'b1;
            end else begin
                pc_en_c  = 1'b1;
                pr1_en_c = 1'b1;
            end
        end
    end

    // Reset forces every control low immediately, independent of the clock.
    assign pc_en           = pc_en_c      && !rst;
    assign pr1_en          = pr1_en_c     && !rst;
    assign pr2_en          = pr2_en_c     && !rst;
    assign pr3_en          = pr3_en_c     && !rst;
    assign pr4_en          = pr4_en_c     && !rst;
    assign pr1_flush       = pr1_flush_c  && !rst;
    assign pr2_bubble      = pr2_bubble_c && !rst;
    assign pr4_bubble      = pr4_bubble_c && !rst;
    assign state           = state_q;
    assign stall_cnt       = stall_q;
    assign mem_timeout_err = err_q;

    // State, wait counter and sticky error; the stall counter saturates
    // instead of wrapping and ignores the HALTED state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            if (!pc_en_c && (state_q != ST_HALTED) && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. Directed sequences from the
// test plan followed by randomized episodes, all compared cycle by cycle
// against a behavioural model of the stall/flush rules. The DUT uses a small
// timeout and a narrow stall counter so both limits are reachable.
module tb_pipeline_hazard_ctrl;

    localparam int RW  = 3;
    localparam int TMO = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_is_load;
    logic          branch_taken, mem_req, mem_ready, halt;
    logic          pc_en, pr1_en, pr2_en, pr3_en, pr4_en;
    logic          pr1_flush, pr2_bubble, pr4_bubble;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt;
    logic          mem_timeout_err;

    int checks = 0;
    int passes = 0;

    // Behavioural model: mode 0 run, 1 waiting on memory, 2 halted.
    int mMode  = 0;
    int mWait  = 0;
    int mStall = 0;
    int mErr   = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (RW),
        .MEM_TIMEOUT(TMO),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rd          (ex_rd),
        .ex_is_load     (ex_is_load),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .halt           (halt),
        .pc_en          (pc_en),
        .pr1_en         (pr1_en),
        .pr2_en         (pr2_en),
        .pr3_en         (pr3_en),
        .pr4_en         (pr4_en),
        .pr1_flush      (pr1_flush),
        .pr2_bubble     (pr2_bubble),
        .pr4_bubble     (pr4_bubble),
        .state          (state),
        .stall_cnt      (stall_cnt),
        .mem_timeout_err(mem_timeout_err)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                      tag, observed, expected, $time);
    endtask

    // Control bundle order: {pc,pr1,pr2,pr3,pr4,flush1,bubble2,bubble4}.
    function automatic logic [7:0] ctlBus();
        return {pc_en, pr1_en, pr2_en, pr3_en, pr4_en, pr1_flush, pr2_bubble, pr4_bubble};
    endfunction

    function automatic logic [7:0] expectedCtl();
        logic hazard;
        hazard = ex_is_load && (ex_rd != 0) &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (rst || mMode == 2 || halt) return 8'b0000_0000;
        if (!mem_ready && (mMode == 1 || mem_req)) return 8'b0000_1001;
        if (branch_taken) return 8'b1111_1110;
        if (hazard) return 8'b0011_1010;
        return 8'b1111_1000;
    endfunction

    // Advance the model by one clock edge given the outputs it predicted.
    task automatic modelStep(input logic [7:0] ctl);
        if (mMode != 2 && ctl[7] == 1'b0 && mStall < CMAX) mStall++;
        if (mMode == 0) begin
            if (halt) mMode = 2;
            else if (mem_req && !mem_ready) begin mMode = 1; mWait = 1; end
        end else if (mMode == 1) begin
            if (halt) mMode = 2;
            else if (mem_ready) begin mMode = 0; mWait = 0; end
            else if (mWait == TMO) begin mErr = 1; mMode = 2; end
            else mWait++;
        end
    endtask

    // Entered and left at a falling edge: drive, check, clock, update model.
    task automatic applyStimulus(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                                 input logic u1, input logic u2,
                                 input logic [RW-1:0] rd, input logic ld,
                                 input logic br, input logic mreq,
                                 input logic mrdy, input logic hlt);
        logic [7:0] exp;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_is_load = ld; branch_taken = br;
        mem_req = mreq; mem_ready = mrdy; halt = hlt;
        #1;
        exp = expectedCtl();
        checkOutput("ctl", 32'(ctlBus()), 32'(exp));
        checkOutput("state", 32'(state), 32'(mMode));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(mStall));
        checkOutput("timeout_err", 32'(mem_timeout_err), 32'(mErr));
        @(posedge clk);
        modelStep(exp);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset between edges, confirm outputs drop at once, release at a falling edge.
    task automatic doReset();
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_ctl", 32'(ctlBus()), 32'd0);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("rst_err", 32'(mem_timeout_err), 32'd0);
        mMode = 0; mWait = 0; mStall = 0; mErr = 0;
        @(negedge clk);
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_is_load, branch_taken, mem_req, mem_ready, halt} = '0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_is_load, branch_taken, mem_req, mem_ready, halt} = '0;
        @(negedge clk);
        doReset();

        // Idle after reset: everything flows.
        idle(2);
        checkOutput("idle_ctl", 32'(ctlBus()), 32'hF8);

        // Load-use on rs2, then the same with ex_rd = 0.
        applyStimulus(0, 3, 0, 1, 3, 1, 0, 0, 0, 0);
        #1 checkOutput("lu_cnt", 32'(stall_cnt), 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        #1 checkOutput("lu_r0_cnt", 32'(stall_cnt), 32'd1);

        // Three-cycle memory wait then release.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1 checkOutput("memwait_cnt", 32'(stall_cnt), 32'd3);
        checkOutput("memwait_state", 32'(state), 32'd0);

        // Branch held through a two-cycle wait, then branch with load-use.
        doReset();
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        #1 checkOutput("br_lu_cnt", 32'(stall_cnt), 32'd2);

        // Timeout: RUN stall plus TMO wait cycles, then halted; late ready ignored.
        doReset();
        for (int i = 0; i < TMO + 1; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1 checkOutput("tmo_err", 32'(mem_timeout_err), 32'd1);
        checkOutput("tmo_state", 32'(state), 32'd2);
        checkOutput("tmo_cnt", 32'(stall_cnt), 32'(TMO + 1));
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        idle(2);

        // Stall counter saturation via repeated load-use stalls.
        doReset();
        for (int i = 0; i < CMAX + 3; i++) applyStimulus(1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        #1 checkOutput("sat_cnt", 32'(stall_cnt), 32'(CMAX));

        // Randomized episodes.
        for (int ep = 0; ep < 30; ep++) begin
            doReset();
            for (int c = 0; c < 40; c++) begin
                applyStimulus(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                              1'($urandom), 1'($urandom), RW'($urandom_range(0, 3)),
                              1'($urandom), 1'($urandom_range(0, 3) == 0),
                              1'($urandom), 1'($urandom), 1'($urandom_range(0, 59) == 0));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
